// File: rtl/escritura_pkg.sv
// escritura_pkg: state encoding, default timing and counter width for the RTC write sequencer
package escritura_pkg;
  localparam int CW = 8;
  localparam int T_SET_DEF = 2;
  localparam int T_WR_DEF = 4;
  localparam int T_HOLD_DEF = 2;
  typedef enum logic [2:0] {
    INICIO    = 3'd0,
    DIR_SET   = 3'd1,
    DIR_WR    = 3'd2,
    DIR_HOLD  = 3'd3,
    DATO_SET  = 3'd4,
    DATO_WR   = 3'd5,
    DATO_HOLD = 3'd6,
    FINALIZAR = 3'd7
  } estado_t;
endpackage

// File: rtl/escritura_temporizador.sv
// escritura_temporizador: shared down-counter; loads on i_carga, otherwise counts down and stops at zero
module escritura_temporizador
  import escritura_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  input  logic          i_carga,
  input  logic [CW-1:0] i_valor,
  output logic          o_cero
);
  logic [CW-1:0] r_cnt;
  always_ff @(posedge clk or negedge reset)
    if (!reset) r_cnt <= '0;
    else if (i_carga) r_cnt <= i_valor;
    else if (!o_cero) r_cnt <= r_cnt - 1'b1;
  assign o_cero = r_cnt == '0;
endmodule

// File: rtl/escritura.sv
// escritura: two-phase (address, data) write sequencer for the multiplexed RTC AD bus.
// Define ESCRITURA_ABORTA_EN to abort on iniciar low during the address phase (adds the error port).
module escritura
  import escritura_pkg::*;
#(
  parameter int T_SET  = T_SET_DEF,
  parameter int T_WR   = T_WR_DEF,
  parameter int T_HOLD = T_HOLD_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       iniciar,
  input  logic [7:0] dir,
  input  logic [7:0] dato,
  output logic [7:0] ad_out,
  output logic       ad_oe,
  output logic       cs_n,
  output logic       wr_n,
  output logic       a_d,
  output logic       ocupado,
`ifdef ESCRITURA_ABORTA_EN
  output logic       error,
`endif
  output logic       o_final
);
  localparam logic [CW-1:0] V_SET  = CW'(T_SET - 1);
  localparam logic [CW-1:0] V_WR   = CW'(T_WR - 1);
  localparam logic [CW-1:0] V_HOLD = CW'(T_HOLD - 1);
  estado_t r_estado, w_sig;
  logic [7:0] r_dir, r_dato, w_dir_n;
  logic r_prev, w_inicio, w_cero, w_aborta, w_fase_dir, w_fase_dato, w_carga;
  logic [CW-1:0] w_valor;
  always_comb begin
    w_inicio = (r_estado == INICIO) & iniciar & ~r_prev;
    w_aborta = 1'b0;
    case (r_estado)
      INICIO:    w_sig = w_inicio ? DIR_SET : INICIO;
      DIR_SET:   w_sig = w_cero ? DIR_WR : DIR_SET;
      DIR_WR:    w_sig = w_cero ? DIR_HOLD : DIR_WR;
      DIR_HOLD:  w_sig = w_cero ? DATO_SET : DIR_HOLD;
      DATO_SET:  w_sig = w_cero ? DATO_WR : DATO_SET;
      DATO_WR:   w_sig = w_cero ? DATO_HOLD : DATO_WR;
      DATO_HOLD: w_sig = w_cero ? FINALIZAR : DATO_HOLD;
      default:   w_sig = INICIO;
    endcase
`ifdef ESCRITURA_ABORTA_EN
    if (r_estado inside {DIR_SET, DIR_WR, DIR_HOLD} && !iniciar) begin
      w_aborta = 1'b1;
      w_sig = INICIO;
    end
`endif
    w_fase_dir  = w_sig inside {DIR_SET, DIR_WR, DIR_HOLD};
    w_fase_dato = w_sig inside {DATO_SET, DATO_WR, DATO_HOLD};
    w_dir_n     = w_inicio ? dir : r_dir;
    w_carga     = w_sig != r_estado;
    w_valor     = w_sig inside {DIR_SET, DATO_SET} ? V_SET :
                  w_sig inside {DIR_WR, DATO_WR}   ? V_WR  :
                  w_sig inside {DIR_HOLD, DATO_HOLD} ? V_HOLD : '0;
  end
  escritura_temporizador u_tmr (
    .clk     (clk),
    .reset   (reset),
    .i_carga (w_carga),
    .i_valor (w_valor),
    .o_cero  (w_cero)
  );
  // outputs follow the next state so they switch on the same edge as the FSM
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      r_estado <= INICIO;
      r_prev   <= 1'b0;
      r_dir    <= '0;
      r_dato   <= '0;
      ad_out   <= '0;
      ad_oe    <= 1'b0;
      cs_n     <= 1'b1;
      wr_n     <= 1'b1;
      a_d      <= 1'b0;
      ocupado  <= 1'b0;
      o_final  <= 1'b0;
`ifdef ESCRITURA_ABORTA_EN
      error    <= 1'b0;
`endif
    end else begin
      r_estado <= w_sig;
      r_prev   <= iniciar;
      if (w_inicio) begin
        r_dir  <= dir;
        r_dato <= dato;
      end
      ad_out   <= w_fase_dir ? w_dir_n : w_fase_dato ? r_dato : 8'h00;
      ad_oe    <= w_fase_dir | w_fase_dato;
      cs_n     <= ~(w_fase_dir | w_fase_dato);
      wr_n     <= ~(w_sig inside {DIR_WR, DATO_WR});
      a_d      <= w_fase_dato;
      ocupado  <= w_sig != INICIO;
      o_final  <= w_sig == FINALIZAR;
`ifdef ESCRITURA_ABORTA_EN
      error    <= w_aborta;
`endif
    end
  logic w_unused;
  assign w_unused = w_aborta;
endmodule

// File: tb/tb_escritura.sv
// tb_escritura: vector-table and directed-sequence bench for escritura (default and 1-cycle timing instances)
module tb_escritura;
  logic clk = 1'b0, reset = 1'b0, iniciar = 1'b0;
  logic [7:0] dir = 8'h00, dato = 8'h00;
  logic [7:0] d_ad, p_ad;
  logic d_oe, d_cs, d_wr, d_ad_sel, d_ocu, d_fin;
  logic p_oe, p_cs, p_wr, p_ad_sel, p_ocu, p_fin;
`ifdef ESCRITURA_ABORTA_EN
  logic d_err, p_err;
`endif
  int n_cmp = 0, n_err = 0;

  always #5 clk = ~clk;

  escritura u_dut (
    .clk(clk), .reset(reset), .iniciar(iniciar), .dir(dir), .dato(dato),
    .ad_out(d_ad), .ad_oe(d_oe), .cs_n(d_cs), .wr_n(d_wr), .a_d(d_ad_sel),
    .ocupado(d_ocu),
`ifdef ESCRITURA_ABORTA_EN
    .error(d_err),
`endif
    .o_final(d_fin)
  );

  escritura #(.T_SET(1), .T_WR(1), .T_HOLD(1)) u_p1 (
    .clk(clk), .reset(reset), .iniciar(iniciar), .dir(dir), .dato(dato),
    .ad_out(p_ad), .ad_oe(p_oe), .cs_n(p_cs), .wr_n(p_wr), .a_d(p_ad_sel),
    .ocupado(p_ocu),
`ifdef ESCRITURA_ABORTA_EN
    .error(p_err),
`endif
    .o_final(p_fin)
  );

  typedef struct {
    logic       ini;
    logic [7:0] dir;
    logic [7:0] dato;
    logic [12:0] exp;
    logic       p_fin;
    logic       p_wr;
  } vec_t;

  vec_t tbl [19];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [12:0] dvec();
    return {d_ad, d_oe, d_cs, d_wr, d_ad_sel, d_ocu, d_fin};
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    int first_fin, first_pfin, cnt_d, cnt_p;
    // step k = sample after the k-th edge counting the start edge as 0
    for (int k = 0; k < 19; k++) begin
      logic dp, tp, wl;
      dp = k <= 7;
      tp = k >= 8 && k <= 15;
      wl = (k >= 2 && k <= 5) || (k >= 10 && k <= 13);
      tbl[k].ini   = k <= 7;
      tbl[k].dir   = k < 2 ? 8'h21 : 8'hFF;
      tbl[k].dato  = k < 2 ? 8'h45 : 8'hFF;
      tbl[k].exp   = {dp ? 8'h21 : tp ? 8'h45 : 8'h00, dp | tp, ~(dp | tp), ~wl, tp, k <= 16, k == 16};
      tbl[k].p_fin = k == 6;
      tbl[k].p_wr  = !(k == 1 || k == 4);
    end

    repeat (3) @(posedge clk);
    #1;
    chk("reset_dut", dvec(), {8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0});
    chk("reset_p1", {p_ad, p_oe, p_cs, p_wr, p_ad_sel, p_ocu, p_fin}, {8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0});
    reset = 1'b1;
    tick();
    chk("idle", dvec(), {8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0});

    for (int k = 0; k < 19; k++) begin
      iniciar = tbl[k].ini;
      dir     = tbl[k].dir;
      dato    = tbl[k].dato;
      tick();
      chk($sformatf("basic_step%0d", k), dvec(), tbl[k].exp);
      chk($sformatf("p1_step%0d", k), {p_fin, p_wr}, {tbl[k].p_fin, tbl[k].p_wr});
    end

    iniciar = 1'b0;
    tick();
    dir = 8'h3C;
    dato = 8'hA5;
    cnt_d = 0;
    cnt_p = 0;
    iniciar = 1'b1;
    for (int c = 1; c <= 40; c++) begin
      tick();
      cnt_d += int'(d_fin);
      cnt_p += int'(p_fin);
    end
    chk("held_final_count", cnt_d, 1);
    chk("held_p1_final_count", cnt_p, 1);

    iniciar = 1'b0;
    tick();
    tick();
    dir = 8'h5A;
    dato = 8'hC3;
    iniciar = 1'b1;
    first_fin = 0;
    first_pfin = 0;
    for (int c = 1; c <= 30 && first_fin == 0; c++) begin
      tick();
      if (c == 12) chk("restart_data_wr", {d_ad, d_ad_sel, d_wr, d_cs}, {8'hC3, 1'b1, 1'b0, 1'b0});
      if (d_fin && first_fin == 0) first_fin = c;
      if (p_fin && first_pfin == 0) first_pfin = c;
    end
    chk("restart_final_latency", first_fin, 17);
    chk("p1_final_latency", first_pfin, 7);
    tick();
    chk("final_one_cycle", d_fin, 1'b0);

    iniciar = 1'b0;
    tick();
    dir = 8'h21;
    dato = 8'h45;
    iniciar = 1'b1;
    tick();
    repeat (11) tick();
    chk("pre_reset_data_wr", {d_wr, d_ad_sel, d_ad}, {1'b0, 1'b1, 8'h45});
    #3;
    iniciar = 1'b0;
    reset = 1'b0;
    #1;
    chk("async_reset_bus", {d_cs, d_wr, d_oe, d_ocu, d_ad}, {1'b1, 1'b1, 1'b0, 1'b0, 8'h00});
    cnt_d = 0;
    for (int c = 0; c < 20; c++) begin
      if (c == 2) reset = 1'b1;
      tick();
      cnt_d += int'(d_fin);
    end
    chk("reset_no_final", cnt_d, 0);

`ifdef ESCRITURA_ABORTA_EN
    iniciar = 1'b1;
    tick();
    tick();
    tick();
    chk("abort_in_dir_wr", {d_wr, d_ad_sel, d_err}, {1'b0, 1'b0, 1'b0});
    iniciar = 1'b0;
    tick();
    chk("abort_error", {d_err, d_ocu, d_cs, d_oe, d_fin}, {1'b1, 1'b0, 1'b1, 1'b0, 1'b0});
    tick();
    chk("abort_error_pulse", d_err, 1'b0);
    cnt_d = 0;
    for (int c = 0; c < 20; c++) begin
      tick();
      cnt_d += int'(d_fin);
    end
    chk("abort_no_final", cnt_d, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/escritura.md
Name: escritura

Overview:
- Write-transaction sequencer for the multiplexed 8-bit address/data bus to the external RTC.
- Companion to the read sequencer on the same bus.
- On a start request it latches a register address and a data byte, then drives two phases: an address phase, then a data phase. Each phase has programmable setup, write-pulse and hold times.
- Pulses `final` for one cycle on completion. Sits between the top-level control FSM and the bus pads.

Parameters:
- T_SET, 2, cycles the bus is stable before wr_n falls (range 1..255)
- T_WR, 4, cycles wr_n is held low (range 1..255)
- T_HOLD, 2, cycles the bus is held after wr_n rises (range 1..255)

Ports:
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  asynchronous, active-low reset (reset=0 clears all state immediately)
- iniciar  in  1  start request; a transaction starts on its rising edge
- dir  in  8  RTC register address; sampled at start
- dato  in  8  data byte to write; sampled at start
- ad_out  out  8  value driven on the AD bus
- ad_oe  out  1  AD bus output enable (1 = block drives the bus)
- cs_n  out  1  RTC chip select, active low
- wr_n  out  1  RTC write strobe, active low
- a_d  out  1  address/data select: 0 = address phase, 1 = data phase
- ocupado  out  1  high whenever the FSM is not in INICIO
- final  out  1  one-cycle completion pulse

Behaviour:
- Reset (reset=0, async):
  - state = INICIO; prev_iniciar = 0; counter = 0.
  - ad_out = 0, ad_oe = 0, cs_n = 1, wr_n = 1, a_d = 0, ocupado = 0, final = 0.
- Register duty: every output is registered and is a function of the next state, so it changes on the same edge as the state.
- Start:
  - In INICIO, iniciar=1 with prev_iniciar=0 is a start. On that edge: latch dir_l <= dir, dato_l <= dato, go to DIR_SET.
  - A level held high does not retrigger. iniciar must be seen low in at least one cycle before the next start.
- States and durations:
  - INICIO: idle, outputs at reset values.
  - DIR_SET (T_SET cycles) -> DIR_WR (T_WR) -> DIR_HOLD (T_HOLD) -> DATO_SET (T_SET) -> DATO_WR (T_WR) -> DATO_HOLD (T_HOLD) -> FINALIZAR (1 cycle) -> INICIO.
  - Each timed state loads the counter with its parameter minus 1 on entry and leaves when the counter is 0.
- Outputs per state:
  - DIR_SET, DIR_WR, DIR_HOLD: cs_n=0, ad_oe=1, a_d=0, ad_out=dir_l.
  - DATO_SET, DATO_WR, DATO_HOLD: cs_n=0, ad_oe=1, a_d=1, ad_out=dato_l.
  - wr_n=0 only in DIR_WR and DATO_WR.
  - FINALIZAR: final=1, bus released (ad_oe=0, ad_out=0, cs_n=1).
- Latency: final is high exactly 2*(T_SET+T_WR+T_HOLD)+1 cycles after the start edge. With defaults this is 17 cycles.
- Input stability: changes to dir or dato after the start edge have no effect on the current transaction.
- iniciar falling mid-transaction: ignored; the transaction completes (unless the optional feature is enabled).
- Reset mid-operation: bus released within the same cycle (asynchronous), no final pulse.
- Illegal state encoding: recovers to INICIO on the next edge with reset outputs.

Optional Feature:
- Macro: ESCRITURA_ABORTA_EN.
- Defined:
  - iniciar=0 in any DIR_* state aborts the transaction. Next edge goes to INICIO with reset outputs.
  - An error output, error (1 bit), pulses high for 1 cycle on abort. final is not pulsed.
  - Data phases are never aborted.
- Undefined: no error port; iniciar is ignored after the start edge.

Decomposition:
- Package escritura_pkg holds:
  - state encoding: 3-bit constants INICIO, DIR_SET, DIR_WR, DIR_HOLD, DATO_SET, DATO_WR, DATO_HOLD, FINALIZAR;
  - default timing constants;
  - counter width (8).
- Sub-module temporizador: 8-bit down-counter.
  - Inputs: load, load value.
  - Output: cero flag.
  - Instantiated once and shared by all timed states.

Test Plan:
- Basic write: reset released, dir=8'h21, dato=8'h45, iniciar rises.
  - Bus shows 8'h21 with a_d=0 and wr_n low for 4 cycles, then 8'h45 with a_d=1 and wr_n low for 4 cycles.
  - final is high 17 cycles after the start edge, for 1 cycle.
- Held start: iniciar held high for 40 cycles -> exactly one transaction and one final pulse. Dropping iniciar low and raising it again starts a second transaction.
- Input change: dir/dato changed to 8'hFF two cycles after start -> bus still shows 8'h21 / 8'h45.
- Async reset: reset=0 in the middle of DATO_WR -> cs_n=1, wr_n=1, ad_oe=0 before the next clock edge; final is never asserted.
- Parameters: T_SET=1, T_WR=1, T_HOLD=1 -> each phase state lasts one cycle; final at cycle 7.
- With ESCRITURA_ABORTA_EN: iniciar dropped in DIR_WR -> error pulses 1 cycle, FSM returns to INICIO, no final pulse.
